// File: rtl/writeback_arbiter.sv
// Write-back arbiter: owns the single register-file write port.
// Merges single-cycle ALU results with memory/multiply results that are
// buffered in a small circular FIFO, and drives one registered write per cycle.
// Writes to r0 are dropped here and never take a write slot.
// Optional feature: define WB_BYPASS_EN to let a memory result skip an empty
// FIFO and reach the output registers with one cycle of latency.
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    output logic                          alu_stall,
    input  logic                          mem_valid,
    input  logic [4:0]                    mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          mem_ready,
    output logic                          we,
    output logic [4:0]                    rd,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]            fifo_rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic full;
    logic empty;
    logic alu_sel;
    logic pop;
    logic mem_xfer;
    logic push;
    logic bypass;

    // Source selection, handshakes and next occupancy
    always_comb begin
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        empty    = (count_q == '0);
        alu_sel  = !full && alu_valid && (alu_rd != 5'd0);
        // A full FIFO preempts the ALU so the memory side can always make progress
        pop      = full || (!alu_sel && !empty);
        mem_xfer = mem_valid && !full;
`ifdef WB_BYPASS_EN
        bypass   = mem_xfer && (mem_rd != 5'd0) && empty && !alu_sel;
`else
        bypass   = 1'b0;
`endif
        // r0 results complete the handshake but are never stored
        push     = mem_xfer && (mem_rd != 5'd0) && !bypass;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign mem_ready  = !full;
    assign alu_stall  = full;
    assign fifo_count = count_q;

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= mem_rd;
            fifo_data_mem[wr_ptr_q] <= mem_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Registered write port; rd and write_data hold when no write is issued
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we         <= 1'b0;
            rd         <= 5'd0;
            write_data <= '0;
        end else if (pop) begin
            we         <= 1'b1;
            rd         <= fifo_rd_mem[rd_ptr_q];
            write_data <= fifo_data_mem[rd_ptr_q];
        end else if (alu_sel) begin
            we         <= 1'b1;
            rd         <= alu_rd;
            write_data <= alu_data;
        end else if (bypass) begin
            we         <= 1'b1;
            rd         <= mem_rd;
            write_data <= mem_data;
        end else begin
            we         <= 1'b0;
        end
    end

endmodule
